// File: rtl/payload_char_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : payload_char_decoder
//  Purpose  : Front end of the payload engines. Accepts the packet payload as
//             a 64-bit AXI-Stream, serializes it one byte per clock, and
//             decodes each byte onto a registered 256-bit one-hot character
//             bus. Each packet is framed with sod/eod pulses.
//
//  Ports    : clk            rising-edge clock
//             resetn         asynchronous active-low reset
//             s_axis_tdata   payload word, byte 0 = [7:0] first on the wire
//             s_axis_tkeep   byte valid mask (all ones except on tlast word)
//             s_axis_tvalid  word valid
//             s_axis_tready  word accepted when tvalid & tready
//             s_axis_tlast   last word of the packet payload
//             char_onehot    one-hot decode of the current byte (0 when idle)
//             char_byte      current (optionally case-folded) byte
//             char_en        byte strobe / engine clock enable
//             sod            start-of-data pulse, engines clear on it
//             eod            end-of-data pulse, after the last byte
//             busy           high from word accept until eod completes
//
//  Revision : 1.0  initial release
// ============================================================================
module payload_char_decoder #(
    parameter int DATA_WIDTH = 64,
    parameter int CASE_FOLD  = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [255:0]            char_onehot,
    output logic [7:0]              char_byte,
    output logic                    char_en,
    output logic                    sod,
    output logic                    eod,
    output logic                    busy
);

    localparam int c_keep_w = DATA_WIDTH / 8;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_sod   = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_eod   = 2'd3;

    // Number of bytes in a word: highest set keep bit + 1. Holes below that
    // bit are ignored, the word is treated as contiguous.
    function automatic logic [3:0] f_nbytes(input logic [c_keep_w-1:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < c_keep_w; i++) begin
            if (keep[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

    function automatic logic [7:0] f_fold(input logic [7:0] b);
        if (CASE_FOLD != 0 && b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
        return b;
    endfunction

    // Registered state
    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_last;
    logic [3:0]            r_nbytes;
    logic [2:0]            r_ptr;     // index of the byte currently on the bus
    logic                  r_first;   // next accepted word starts a packet
    logic                  r_busy;
    logic                  r_tready;
    logic                  r_sod;
    logic                  r_eod;
    logic                  r_char_en;
    logic [7:0]            r_char_byte;
    logic [255:0]          r_char_onehot;

    // Next-state values
    logic [1:0]            w_state;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_last;
    logic [3:0]            w_nbytes;
    logic [2:0]            w_ptr;
    logic                  w_first;
    logic                  w_busy;
    logic                  w_tready;
    logic                  w_sod;
    logic                  w_eod;
    logic                  w_emit;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_sel_word;
    logic [2:0]            w_sel_idx;
    logic [3:0]            w_sel_nbytes;
    logic                  w_sel_last;
    logic [7:0]            w_raw_byte;
    logic [7:0]            w_fold_byte;
    logic [7:0]            w_char_byte;
    logic [255:0]          w_char_onehot;

    logic       w_accept;
    logic [3:0] w_in_nbytes;
    logic       w_last_byte;

    assign w_accept    = s_axis_tvalid & r_tready;
    assign w_in_nbytes = f_nbytes(s_axis_tkeep);
    assign w_last_byte = ({1'b0, r_ptr} == (r_nbytes - 4'd1));

    always_comb begin
        w_state      = r_state;
        w_word       = r_word;
        w_last       = r_last;
        w_nbytes     = r_nbytes;
        w_ptr        = r_ptr;
        w_first      = r_first;
        w_busy       = r_busy;
        w_tready     = 1'b0;
        w_sod        = 1'b0;
        w_eod        = 1'b0;
        w_emit       = 1'b0;
        w_load       = 1'b0;
        w_sel_word   = r_word;
        w_sel_idx    = 3'd0;
        w_sel_nbytes = r_nbytes;
        w_sel_last   = r_last;

        case (r_state)
            c_st_idle: begin
                w_tready = 1'b1;
                if (w_accept) begin
                    w_word   = s_axis_tdata;
                    w_last   = s_axis_tlast;
                    w_nbytes = w_in_nbytes;
                    w_ptr    = 3'd0;
                    w_busy   = 1'b1;
                    if (r_first) begin
                        w_state  = c_st_sod;
                        w_sod    = 1'b1;
                        w_tready = 1'b0;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            c_st_sod: begin
                w_first = 1'b0;
                if (r_nbytes != 4'd0) begin
                    w_state = c_st_shift;
                    w_emit  = 1'b1;
                    w_ptr   = 3'd0;
                end else begin
                    w_state = c_st_eod;
                    w_eod   = 1'b1;
                end
            end
            c_st_shift: begin
                if (w_last_byte) begin
                    if (r_last) begin
                        w_state = c_st_eod;
                        w_eod   = 1'b1;
                    end else if (w_accept) begin
                        w_word   = s_axis_tdata;
                        w_last   = s_axis_tlast;
                        w_nbytes = w_in_nbytes;
                        w_ptr    = 3'd0;
                        w_load   = 1'b1;
                    end else begin
                        // Packet continues later; first flag stays clear so
                        // the next word does not produce another sod.
                        w_state  = c_st_idle;
                        w_tready = 1'b1;
                    end
                end else begin
                    w_ptr     = r_ptr + 3'd1;
                    w_emit    = 1'b1;
                    w_sel_idx = r_ptr + 3'd1;
                end
            end
            c_st_eod: begin
                w_first  = 1'b1;
                w_busy   = 1'b0;
                w_state  = c_st_idle;
                w_tready = 1'b1;
            end
            default: begin
                w_state = c_st_idle;
            end
        endcase

        // A continuation word goes straight to its byte 0, taken from the
        // bus since the word register only updates at this edge.
        if (w_load) begin
            w_sel_word   = s_axis_tdata;
            w_sel_idx    = 3'd0;
            w_sel_nbytes = w_in_nbytes;
            w_sel_last   = s_axis_tlast;
            if (w_in_nbytes != 4'd0) begin
                w_state = c_st_shift;
                w_emit  = 1'b1;
            end else if (s_axis_tlast) begin
                w_state = c_st_eod;
                w_eod   = 1'b1;
            end else begin
                w_state  = c_st_idle;
                w_tready = 1'b1;
            end
        end

        // Open tready while the final byte of a non-last word is on the bus
        // so the next word loads without a bubble.
        if (w_emit) begin
            w_tready = ({1'b0, w_sel_idx} == (w_sel_nbytes - 4'd1)) && !w_sel_last;
        end
    end

    assign w_raw_byte    = w_sel_word[{w_sel_idx, 3'b000} +: 8];
    assign w_fold_byte   = f_fold(w_raw_byte);
    assign w_char_byte   = w_emit ? w_fold_byte : 8'd0;
    assign w_char_onehot = w_emit ? (256'd1 << w_fold_byte) : 256'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= c_st_idle;
            r_word        <= '0;
            r_last        <= 1'b0;
            r_nbytes      <= 4'd0;
            r_ptr         <= 3'd0;
            r_first       <= 1'b1;
            r_busy        <= 1'b0;
            r_tready      <= 1'b0;
            r_sod         <= 1'b0;
            r_eod         <= 1'b0;
            r_char_en     <= 1'b0;
            r_char_byte   <= 8'd0;
            r_char_onehot <= '0;
        end else begin
            r_state       <= w_state;
            r_word        <= w_word;
            r_last        <= w_last;
            r_nbytes      <= w_nbytes;
            r_ptr         <= w_ptr;
            r_first       <= w_first;
            r_busy        <= w_busy;
            r_tready      <= w_tready;
            r_sod         <= w_sod;
            r_eod         <= w_eod;
            r_char_en     <= w_emit;
            r_char_byte   <= w_char_byte;
            r_char_onehot <= w_char_onehot;
        end
    end

    assign s_axis_tready = r_tready;
    assign char_onehot   = r_char_onehot;
    assign char_byte     = r_char_byte;
    assign char_en       = r_char_en;
    assign sod           = r_sod;
    assign eod           = r_eod;
    assign busy          = r_busy;

endmodule
`default_nettype wire
